// File: rtl/sram_port_arbiter_if.sv
// SRAM-like split-transaction bus: req/addr_ok request phase, data_ok/rdata response phase.
// master drives the request, slave returns acceptance and response.
interface sram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req;
   logic                  wr;
   logic [1:0]            size;
   logic [3:0]            wstrb;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [31:0]           rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and load/store (data), returning responses in order.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority data over inst.
module sram_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_WIDTH      = 32
) (
   input  logic               clock,
   input  logic               reset_,
   sram_port_arbiter_if.slave  inst,
   sram_port_arbiter_if.slave  data,
   sram_port_arbiter_if.master mem
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]       state_q;
   logic             lock_owner_q;
   logic             owner_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic pop;
   logic space;
   logic gnt_valid;
   logic sel;
   logic accept;
   logic head;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic rr_last_q;
`endif

   assign pop   = mem.data_ok && (count_q != '0);
   assign space = (count_q != CNT_MAX) || pop;

   // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_valid = 1'b0;
      sel       = OWN_INST;
      if (state_q == ST_LOCK) begin
         gnt_valid = 1'b1;
         sel       = lock_owner_q;
      end else if (space) begin
         gnt_valid = inst.req || data.req;
         if (inst.req && data.req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            sel = (rr_last_q == OWN_INST) ? OWN_DATA : OWN_INST;
`else
            sel = OWN_DATA;
`endif
         end else begin
            sel = data.req ? OWN_DATA : OWN_INST;
         end
      end
   end

   // Fetches are always word reads, so the write fields are forced to zero for the inst channel.
   assign mem.req   = reset_ && gnt_valid && (sel ? data.req : inst.req);
   assign mem.wr    = sel ? data.wr    : 1'b0;
   assign mem.size  = sel ? data.size  : 2'd2;
   assign mem.wstrb = sel ? data.wstrb : 4'h0;
   assign mem.addr  = sel ? data.addr  : inst.addr;
   assign mem.wdata = sel ? data.wdata : 32'h0;

   assign accept       = mem.req && mem.addr_ok;
   assign inst.addr_ok = accept && (sel == OWN_INST);
   assign data.addr_ok = accept && (sel == OWN_DATA);

   assign head         = owner_q[rd_ptr_q];
   assign inst.data_ok = pop && (head == OWN_INST);
   assign data.data_ok = pop && (head == OWN_DATA);
   assign inst.rdata   = inst.data_ok ? mem.rdata : 32'h0;
   assign data.rdata   = data.data_ok ? mem.rdata : 32'h0;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q      <= ST_IDLE;
         lock_owner_q <= OWN_INST;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         if (mem.req && !mem.addr_ok) begin
            state_q      <= ST_LOCK;
            lock_owner_q <= sel;
         end else begin
            state_q <= ST_IDLE;
         end
         if (accept) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: owner storage has no reset; count_q alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (accept) owner_q[wr_ptr_q] <= sel;
   end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_)     rr_last_q <= OWN_INST;
      else if (accept) rr_last_q <= sel;
   end
`endif

`ifndef SYNTHESIS
   // A response with nothing outstanding is dropped; flag it so a misbehaving memory is noticed.
   assert property (@(posedge clock) disable iff (!reset_) !(mem.data_ok && count_q == '0))
      else $warning("sram_port_arbiter: response with no outstanding request dropped");
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and random stimulus for sram_port_arbiter, checked every cycle against a queue-based model.
module tb_sram_port_arbiter;

   localparam int MAXO = 2;
   localparam int AW   = 32;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clock  = 1'b0;
   logic reset_ = 1'b0;
   always #5 clock = ~clock;

   sram_port_arbiter_if #(.ADDR_WIDTH(AW)) inst_bus ();
   sram_port_arbiter_if #(.ADDR_WIDTH(AW)) data_bus ();
   sram_port_arbiter_if #(.ADDR_WIDTH(AW)) mem_bus ();

   sram_port_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .inst   (inst_bus),
      .data   (data_bus),
      .mem    (mem_bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: ordered queue of owners (1 = data, 0 = inst) plus a pending-grant latch.
   bit q[$];
   bit m_locked, m_lock_owner, m_rr_last;
   bit e_req, e_sel, e_accept, e_pop, e_head;
   bit acc_inst, acc_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_bus.req   = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
      inst_bus.wstrb = 4'h0; inst_bus.addr = '0; inst_bus.wdata = '0;
      data_bus.req   = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0;
      data_bus.wstrb = 4'h0; data_bus.addr = '0; data_bus.wdata = '0;
      mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;
   endtask

   // Settle inputs, derive the expected outputs from the model and compare.
   task automatic eval();
      int occ;
      bit valid;
      #3;
      occ    = (reset_ === 1'b1) ? q.size() : 0;
      e_pop  = (mem_bus.data_ok === 1'b1) && (occ > 0);
      e_head = (occ > 0) ? q[0] : 1'b0;
      valid  = 1'b0;
      e_sel  = 1'b0;
      if (reset_ !== 1'b1) begin
         valid = 1'b0;
      end else if (m_locked) begin
         valid = 1'b1;
         e_sel = m_lock_owner;
      end else if (occ < MAXO || e_pop) begin
         valid = inst_bus.req || data_bus.req;
         if (inst_bus.req && data_bus.req) e_sel = RR_EN ? !m_rr_last : 1'b1;
         else                              e_sel = data_bus.req;
      end
      e_req    = valid && (e_sel ? data_bus.req : inst_bus.req);
      e_accept = e_req && mem_bus.addr_ok;
      check("mem_req",      mem_bus.req,      e_req);
      check("inst_addr_ok", inst_bus.addr_ok, e_accept && !e_sel);
      check("data_addr_ok", data_bus.addr_ok, e_accept && e_sel);
      check("inst_data_ok", inst_bus.data_ok, e_pop && !e_head);
      check("data_data_ok", data_bus.data_ok, e_pop && e_head);
      check("inst_rdata",   inst_bus.rdata,   (e_pop && !e_head) ? mem_bus.rdata : 32'h0);
      check("data_rdata",   data_bus.rdata,   (e_pop && e_head)  ? mem_bus.rdata : 32'h0);
      if (e_req) begin
         check("mem_addr",  mem_bus.addr,  e_sel ? data_bus.addr  : inst_bus.addr);
         check("mem_wr",    mem_bus.wr,    e_sel ? data_bus.wr    : 1'b0);
         check("mem_size",  mem_bus.size,  e_sel ? data_bus.size  : 2'd2);
         check("mem_wstrb", mem_bus.wstrb, e_sel ? data_bus.wstrb : 4'h0);
         check("mem_wdata", mem_bus.wdata, e_sel ? data_bus.wdata : 32'h0);
      end
   endtask

   // Advance one clock and apply the model's state update at the same edge.
   task automatic adv();
      @(posedge clock);
      acc_inst = 1'b0;
      acc_data = 1'b0;
      if (reset_ !== 1'b1) begin
         q.delete();
         m_locked = 1'b0; m_lock_owner = 1'b0; m_rr_last = 1'b0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_accept) begin
            q.push_back(e_sel);
            m_rr_last = e_sel;
            acc_inst  = !e_sel;
            acc_data  = e_sel;
         end
         m_locked     = e_req && !mem_bus.addr_ok;
         m_lock_owner = e_sel;
      end
      #1;
   endtask

   initial begin
      idle_inputs();
      m_locked = 1'b0; m_lock_owner = 1'b0; m_rr_last = 1'b0;

      // Reset: outputs quiet even when a request and acceptance are presented.
      eval();
      adv();
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; mem_bus.addr_ok = 1'b1;
      eval();
      check("rst_mem_req", mem_bus.req, 1'b0);
      check("rst_inst_addr_ok", inst_bus.addr_ok, 1'b0);
      adv();
      idle_inputs();
      reset_ = 1'b1;

      // 1: single fetch, response one cycle later.
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000; mem_bus.addr_ok = 1'b1;
      eval();
      check("t1_inst_addr_ok", inst_bus.addr_ok, 1'b1);
      check("t1_mem_addr", mem_bus.addr, 32'hBFC0_0000);
      check("t1_data_addr_ok", data_bus.addr_ok, 1'b0);
      adv();
      idle_inputs();
      mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h2408_0001;
      eval();
      check("t1_inst_data_ok", inst_bus.data_ok, 1'b1);
      check("t1_inst_rdata", inst_bus.rdata, 32'h2408_0001);
      check("t1_data_data_ok", data_bus.data_ok, 1'b0);
      adv();
      idle_inputs();

      // 2: simultaneous requests, data store wins, responses return in order.
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0004;
      data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd2; data_bus.wstrb = 4'hF;
      data_bus.addr = 32'h8000_0010; data_bus.wdata = 32'h1234_5678;
      mem_bus.addr_ok = 1'b1;
      eval();
      check("t2_data_first", data_bus.addr_ok, 1'b1);
      check("t2_mem_wstrb", mem_bus.wstrb, 4'hF);
      adv();
      data_bus.req = 1'b0;
      eval();
      check("t2_inst_second", inst_bus.addr_ok, 1'b1);
      adv();
      inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
      mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hA5A5_A5A5;
      eval();
      check("t2_resp_data", data_bus.data_ok, 1'b1);
      adv();
      mem_bus.rdata = 32'h1111_2222;
      eval();
      check("t2_resp_inst", inst_bus.rdata, 32'h1111_2222);
      adv();
      idle_inputs();

      // 3: acceptance stalled while fetch arrives; grant stays on data.
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_0020;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0008; end
         eval();
         check("t3_mem_addr_held", mem_bus.addr, 32'h8000_0020);
         adv();
      end
      mem_bus.addr_ok = 1'b1;
      eval();
      check("t3_data_accept", data_bus.addr_ok, 1'b1);
      adv();
      data_bus.req = 1'b0;
      eval();
      adv();
      inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
      mem_bus.rdata = 32'h0000_00AB;
      eval();
      adv();
      mem_bus.rdata = 32'h0000_00CD;
      eval();
      adv();
      idle_inputs();

      // 4: fill to MAX_OUTSTANDING, then a response frees a slot in the same cycle.
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0010; mem_bus.addr_ok = 1'b1;
      eval();
      adv();
      inst_bus.req = 1'b0; data_bus.req = 1'b1; data_bus.addr = 32'h8000_0028;
      eval();
      adv();
      data_bus.addr = 32'h8000_0030;
      eval();
      check("t4_full_mem_req", mem_bus.req, 1'b0);
      check("t4_full_addr_ok", data_bus.addr_ok, 1'b0);
      adv();
      mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0BAD_F00D;
      eval();
      check("t4_pop_accept", data_bus.addr_ok, 1'b1);
      check("t4_pop_inst_ok", inst_bus.data_ok, 1'b1);
      adv();
      mem_bus.data_ok = 1'b0; data_bus.addr = 32'h8000_0034;
      eval();
      check("t4_still_full", mem_bus.req, 1'b0);
      adv();

      // 5: reset with two outstanding; later responses are dropped.
      idle_inputs();
      reset_ = 1'b0;
      eval();
      adv();
      reset_ = 1'b1;
      mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hFFFF_0000;
      for (int i = 0; i < 2; i++) begin
         eval();
         check("t5_drop_inst", inst_bus.data_ok, 1'b0);
         check("t5_drop_data", data_bus.data_ok, 1'b0);
         adv();
      end
      idle_inputs();
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0020; mem_bus.addr_ok = 1'b1;
      eval();
      check("t5_empty_accept0", inst_bus.addr_ok, 1'b1);
      adv();
      inst_bus.req = 1'b0; data_bus.req = 1'b1; data_bus.addr = 32'h8000_0040;
      eval();
      check("t5_empty_accept1", data_bus.addr_ok, 1'b1);
      adv();
      idle_inputs();
      mem_bus.data_ok = 1'b1;
      eval(); adv();
      eval(); adv();
      idle_inputs();

      // 6: both channels request continuously after a fresh reset.
      reset_ = 1'b0;
      eval();
      adv();
      reset_ = 1'b1;
      inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_1000;
      data_bus.req = 1'b1; data_bus.addr = 32'h8000_1000;
      mem_bus.addr_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_bus.data_ok = (i > 0); mem_bus.rdata = $urandom();
         eval();
         check("t6_data_grant", data_bus.addr_ok, RR_EN ? (i % 2 == 0) : 1'b1);
         check("t6_inst_grant", inst_bus.addr_ok, RR_EN ? (i % 2 == 1) : 1'b0);
         adv();
         if (acc_inst) inst_bus.addr = inst_bus.addr + 32'd4;
         if (acc_data) data_bus.addr = data_bus.addr + 32'd4;
      end
      idle_inputs();
      mem_bus.data_ok = 1'b1;
      eval();
      adv();
      idle_inputs();

      // Random traffic: requesters hold fields until accepted; memory answers only when owed.
      for (int n = 0; n < 400; n++) begin
         if (!inst_bus.req || acc_inst) begin
            inst_bus.req  = 1'($urandom_range(0, 1));
            inst_bus.addr = $urandom() & 32'hFFFF_FFFC;
         end
         if (!data_bus.req || acc_data) begin
            data_bus.req   = 1'($urandom_range(0, 1));
            data_bus.wr    = 1'($urandom_range(0, 1));
            data_bus.size  = 2'($urandom_range(0, 2));
            data_bus.wstrb = 4'($urandom());
            data_bus.addr  = $urandom();
            data_bus.wdata = $urandom();
         end
         mem_bus.addr_ok = ($urandom_range(0, 9) < 6);
         mem_bus.data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_bus.rdata   = $urandom();
         eval();
         adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
